// File: rtl/config_pkg.sv
// Shared constants and types for the keyboard-driven configuration sequencer.
package config_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_YES   = 8'h35;
  localparam logic [7:0] SC_NO    = 8'h31;

  // Digits 0..8 on the main row, set 2 scan codes
  localparam logic [8:0][7:0] TEMP_CODES = {
    8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
  };

  localparam logic [1:0] DT_NONE = 2'd0;
  localparam logic [1:0] DT_TEMP = 2'd1;
  localparam logic [1:0] DT_IGN  = 2'd2;
  localparam logic [1:0] DT_PRES = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TEMP = 3'd1,
    ST_IGN  = 3'd2,
    ST_PRES = 3'd3,
    ST_SAVE = 3'd4
  } state_t;

  typedef struct packed {
    logic       save;
    logic       done;
    logic       error;
    logic       timeout;
    logic       active;
    logic [1:0] data_type;
  } status_t;

  function automatic logic is_temp_code(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 9; i++)
      if (TEMP_CODES[i] == code) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Per-field inactivity counter; saturates at the limit and flags expiry while enabled.
module inactivity_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (clear)                   cnt <= '0;
    else if (enable && (cnt != LAST)) cnt <= cnt + 1'b1;
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/config_sequencer.sv
// Walks the user through temperature / ignition / presence entry from PS/2 make codes,
// emitting a one-cycle save strobe per accepted field; every output is registered.
module config_sequencer
  import config_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  output logic       save,
  output logic [1:0] data_type,
  output logic [7:0] key_out,
  output logic       config_active,
  output logic       done_tick,
  output logic       error_tick,
  output logic       timeout_tick
);

  state_t     state, state_d;
  logic [1:0] field, field_d;
  logic [7:0] key_q, key_d;
  logic       skip, skip_d;
  logic       pend_vld, pend_vld_d;
  logic [7:0] pend_data, pend_data_d;
  status_t    st_q, st_d;

  logic       byte_vld, make, in_field, expired;
  logic [7:0] byte_val;

  assign in_field = (state == ST_TEMP) || (state == ST_IGN) || (state == ST_PRES);

  inactivity_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_done_tick || byte_vld || !in_field),
    .enable  (in_field),
    .expired (expired)
  );

  always_comb begin
    state_d     = state;
    field_d     = field;
    key_d       = key_q;
    skip_d      = skip;
    pend_vld_d  = pend_vld;
    pend_data_d = pend_data;
    byte_vld    = 1'b0;
    byte_val    = rx_data;
    make        = 1'b0;
    st_d        = '0;

    if (state == ST_SAVE) begin
      // Bytes arriving during SAVE wait one cycle for the successor state
      if (rx_done_tick && !pend_vld) begin
        pend_vld_d  = 1'b1;
        pend_data_d = rx_data;
      end
      case (field)
        DT_TEMP: state_d = ST_IGN;
        DT_IGN:  state_d = ST_PRES;
        default: begin
          state_d = ST_IDLE;
          st_d.done = 1'b1;
        end
      endcase
    end else begin
      // Pending byte goes first; a concurrent strobe refills the freed slot
      if (pend_vld) begin
        byte_vld    = 1'b1;
        byte_val    = pend_data;
        pend_vld_d  = rx_done_tick;
        pend_data_d = rx_data;
      end else if (rx_done_tick) begin
        byte_vld = 1'b1;
      end

      if (byte_vld) begin
        if (skip)                                            skip_d = 1'b0;
        else if ((byte_val == SC_BREAK) || (byte_val == SC_EXT)) skip_d = 1'b1;
        else                                                 make   = 1'b1;
      end

      if (make) begin
        case (state)
          ST_IDLE: if (byte_val == SC_ENTER) state_d = ST_TEMP;
          ST_TEMP: begin
            if (is_temp_code(byte_val)) begin
              key_d   = byte_val;
              field_d = DT_TEMP;
              state_d = ST_SAVE;
            end else if (byte_val == SC_ESC) begin
              state_d = ST_IDLE;
            end else if (byte_val != SC_ENTER) begin
              st_d.error = 1'b1;
            end
          end
          default: begin
            if ((byte_val == SC_YES) || (byte_val == SC_NO)) begin
              key_d   = byte_val;
              field_d = (state == ST_IGN) ? DT_IGN : DT_PRES;
              state_d = ST_SAVE;
            end else if (byte_val == SC_ESC) begin
              state_d = ST_IDLE;
            end else if (byte_val != SC_ENTER) begin
              st_d.error = 1'b1;
            end
          end
        endcase
      end else if (expired && !byte_vld) begin
        state_d      = ST_IDLE;
        st_d.timeout = 1'b1;
      end
    end

    st_d.save   = (state_d == ST_SAVE);
    st_d.active = (state_d != ST_IDLE);
    case (state_d)
      ST_TEMP: st_d.data_type = DT_TEMP;
      ST_IGN:  st_d.data_type = DT_IGN;
      ST_PRES: st_d.data_type = DT_PRES;
      ST_SAVE: st_d.data_type = field_d;
      default: st_d.data_type = DT_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      field     <= DT_NONE;
      key_q     <= 8'h00;
      skip      <= 1'b0;
      pend_vld  <= 1'b0;
      pend_data <= 8'h00;
      st_q      <= '0;
    end else begin
      state     <= state_d;
      field     <= field_d;
      key_q     <= key_d;
      skip      <= skip_d;
      pend_vld  <= pend_vld_d;
      pend_data <= pend_data_d;
      st_q      <= st_d;
    end
  end

  assign save          = st_q.save;
  assign done_tick     = st_q.done;
  assign error_tick    = st_q.error;
  assign timeout_tick  = st_q.timeout;
  assign config_active = st_q.active;
  assign data_type     = st_q.data_type;
  assign key_out       = key_q;

endmodule
